e203_exu_branchslv_pipe: RTL and testbench

Parametrised, registered successor of the EXU branch-resolve stage. It resolves committed branch, jump, fence.i, mret and dret instructions against the IFU prediction. On a misprediction or mandatory redirect, it captures the redirect into a one-entry pending slot and drives a registered flush request to the commit/flush arbiter. It also keeps a saturating misprediction counter for performance monitoring.

---
 rtl/e203_exu_branchslv_pipe.sv | 112 +++++++++++
 tb/tb_e203_exu_branchslv_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_branchslv_pipe.sv
// Registered branch-resolve stage: captures mispredicts and mandatory redirects into a
// one-entry pending slot, drives a flush request and counts bjp mispredicts.
module e203_exu_branchslv_pipe #(
    parameter int PC_W   = 32,
    parameter int XLEN   = 32,
    parameter int CNT_W  = 16,
    parameter int RVC_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmt_i_valid,
    output logic              cmt_i_ready,
    input  logic              cmt_i_rv32,
    input  logic              cmt_i_dret,
    input  logic              cmt_i_mret,
    input  logic              cmt_i_fencei,
    input  logic              cmt_i_bjp,
    input  logic              cmt_i_bjp_prdt,
    input  logic              cmt_i_bjp_rslv,
    input  logic [PC_W-1:0]   cmt_i_pc,
    input  logic [XLEN-1:0]   cmt_i_imm,
    input  logic [PC_W-1:0]   csr_epc_r,
    input  logic [PC_W-1:0]   csr_dpc_r,
    input  logic              nonalu_excpirq_flush_req_raw,
    output logic              brchmis_flush_req,
    input  logic              brchmis_flush_ack,
    output logic [PC_W-1:0]   brchmis_flush_pc,
    output logic              cmt_mret_ena,
    output logic              cmt_dret_ena,
    output logic              cmt_fencei_ena,
    output logic [CNT_W-1:0]  brchmis_cnt
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t            state_p1, state_nxt;
    logic [PC_W-1:0]   target_p1;
    logic              mret_p1, dret_p1, fencei_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic              is_branch, need_flush, capture, bjp_mis, hsk;
    logic [PC_W-1:0]   step, target_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign is_branch  = cmt_i_bjp | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
    assign need_flush = (cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv))
                      | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
    assign capture    = (state_p1 == IDLE) & cmt_i_valid & is_branch & need_flush
                      & ~nonalu_excpirq_flush_req_raw;
    // Only a pure bjp mispredict counts; system redirects share the slot but not the counter.
    assign bjp_mis    = cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv)
                      & ~cmt_i_fencei & ~cmt_i_mret & ~cmt_i_dret;
    assign step       = ((RVC_EN == 0) || cmt_i_rv32) ? PC_W'(4) : PC_W'(2);

    always_comb begin
        target_p0 = cmt_i_pc + cmt_i_imm[PC_W-1:0];
        if (cmt_i_dret)
            target_p0 = csr_dpc_r;
        else if (cmt_i_mret)
            target_p0 = csr_epc_r;
        else if (cmt_i_fencei || cmt_i_bjp_prdt)
            target_p0 = cmt_i_pc + step;
    end

    assign brchmis_flush_req = (state_p1 == PEND) & ~nonalu_excpirq_flush_req_raw & ~rst;
    assign hsk               = brchmis_flush_req & brchmis_flush_ack;
    assign brchmis_flush_pc  = rst ? '0 : target_p1;
    assign cmt_mret_ena      = hsk & mret_p1;
    assign cmt_dret_ena      = hsk & dret_p1;
    assign cmt_fencei_ena    = hsk & fencei_p1;
    assign brchmis_cnt       = cnt_p1;

    always_comb begin
        state_nxt   = state_p1;
        cmt_i_ready = 1'b0;
        case (state_p1)
            IDLE: begin
                cmt_i_ready = ~nonalu_excpirq_flush_req_raw | ~(is_branch & need_flush);
                if (capture) state_nxt = PEND;
            end
            PEND: begin
                if (hsk) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture stage: slot and counter update on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1  <= IDLE;
            target_p1 <= '0;
            mret_p1   <= 1'b0;
            dret_p1   <= 1'b0;
            fencei_p1 <= 1'b0;
            cnt_p1    <= '0;
        end else begin
            state_p1 <= state_nxt;
            if (capture) begin
                target_p1 <= target_p0;
                dret_p1   <= cmt_i_dret;
                mret_p1   <= cmt_i_mret & ~cmt_i_dret;
                fencei_p1 <= cmt_i_fencei & ~cmt_i_mret & ~cmt_i_dret;
                if (bjp_mis) cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

endmodule

// File: tb/tb_e203_exu_branchslv_pipe.sv
// Directed bench: default instance plus RVC_EN=0 and CNT_W=2 variants sharing one stimulus.
module tb_e203_exu_branchslv_pipe;

    logic        clk = 1'b0;
    logic        rst, valid, rv32, dret, mret, fencei, bjp, prdt, rslv, nonalu, ack;
    logic [31:0] pc, imm, epc, dpc;

    logic        ready_a, req_a, mena_a, dena_a, fena_a;
    logic [31:0] fpc_a;
    logic [15:0] cnt_a;
    logic        ready_n, req_n, mena_n, dena_n, fena_n;
    logic [31:0] fpc_n;
    logic [15:0] cnt_n;
    logic        ready_c, req_c, mena_c, dena_c, fena_c;
    logic [31:0] fpc_c;
    logic [1:0]  cnt_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_exu_branchslv_pipe dut (
        .clk(clk), .rst(rst), .cmt_i_valid(valid), .cmt_i_ready(ready_a), .cmt_i_rv32(rv32),
        .cmt_i_dret(dret), .cmt_i_mret(mret), .cmt_i_fencei(fencei), .cmt_i_bjp(bjp),
        .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv), .cmt_i_pc(pc), .cmt_i_imm(imm),
        .csr_epc_r(epc), .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu),
        .brchmis_flush_req(req_a), .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc_a),
        .cmt_mret_ena(mena_a), .cmt_dret_ena(dena_a), .cmt_fencei_ena(fena_a), .brchmis_cnt(cnt_a)
    );

    e203_exu_branchslv_pipe #(.RVC_EN(0)) dut_norvc (
        .clk(clk), .rst(rst), .cmt_i_valid(valid), .cmt_i_ready(ready_n), .cmt_i_rv32(rv32),
        .cmt_i_dret(dret), .cmt_i_mret(mret), .cmt_i_fencei(fencei), .cmt_i_bjp(bjp),
        .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv), .cmt_i_pc(pc), .cmt_i_imm(imm),
        .csr_epc_r(epc), .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu),
        .brchmis_flush_req(req_n), .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc_n),
        .cmt_mret_ena(mena_n), .cmt_dret_ena(dena_n), .cmt_fencei_ena(fena_n), .brchmis_cnt(cnt_n)
    );

    e203_exu_branchslv_pipe #(.CNT_W(2)) dut_cnt2 (
        .clk(clk), .rst(rst), .cmt_i_valid(valid), .cmt_i_ready(ready_c), .cmt_i_rv32(rv32),
        .cmt_i_dret(dret), .cmt_i_mret(mret), .cmt_i_fencei(fencei), .cmt_i_bjp(bjp),
        .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv), .cmt_i_pc(pc), .cmt_i_imm(imm),
        .csr_epc_r(epc), .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu),
        .brchmis_flush_req(req_c), .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc_c),
        .cmt_mret_ena(mena_c), .cmt_dret_ena(dena_c), .cmt_fencei_ena(fena_c), .brchmis_cnt(cnt_c)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; rv32 = 1; dret = 0; mret = 0; fencei = 0; bjp = 0;
        prdt = 0; rslv = 0; nonalu = 0; ack = 0; pc = 0; imm = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        epc = 32'h1234; dpc = 32'h5678;
        tick();
        tick();
        #3;
        checks++;
        if (req_a !== 1'b0 || fpc_a !== 32'h0) begin
            failures++;
            $display("FAIL reset_req_pc: req=%b pc=%h required req=0 pc=0", req_a, fpc_a);
        end
        checks++;
        if (cnt_a !== 16'h0 || {mena_a, dena_a, fena_a} !== 3'b000) begin
            failures++;
            $display("FAIL reset_cnt_ena: cnt=%0d ena=%b required cnt=0 ena=000", cnt_a, {mena_a, dena_a, fena_a});
        end
        rst = 0;
        tick();
    endtask

    task automatic test_correct_predict();
        do_reset();
        valid = 1; bjp = 1; prdt = 1; rslv = 1; pc = 32'h100; imm = 32'h20;
        #3;
        checks++;
        if (ready_a !== 1'b1) begin
            failures++;
            $display("FAIL correct_ready: ready=%b required 1", ready_a);
        end
        tick();
        idle_inputs();
        #3;
        checks++;
        if (req_a !== 1'b0 || cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL correct_noflush: req=%b cnt=%0d required req=0 cnt=0", req_a, cnt_a);
        end
    endtask

    task automatic test_mispredict_taken();
        do_reset();
        valid = 1; bjp = 1; prdt = 0; rslv = 1; pc = 32'h8000_0100; imm = 32'h40;
        tick();
        idle_inputs();
        valid = 1;
        #3;
        checks++;
        if (req_a !== 1'b1 || fpc_a !== 32'h8000_0140) begin
            failures++;
            $display("FAIL taken_flush: req=%b pc=%h required req=1 pc=80000140", req_a, fpc_a);
        end
        checks++;
        if (ready_a !== 1'b0 || cnt_a !== 16'd1) begin
            failures++;
            $display("FAIL taken_stall_cnt: ready=%b cnt=%0d required ready=0 cnt=1", ready_a, cnt_a);
        end
        tick();
        checks++;
        if (req_a !== 1'b1 || fpc_a !== 32'h8000_0140) begin
            failures++;
            $display("FAIL taken_hold: req=%b pc=%h required req=1 pc=80000140", req_a, fpc_a);
        end
        ack = 1;
        tick();
        ack = 0;
        #3;
        checks++;
        if (req_a !== 1'b0 || ready_a !== 1'b1) begin
            failures++;
            $display("FAIL taken_release: req=%b ready=%b required req=0 ready=1", req_a, ready_a);
        end
    endtask

    task automatic test_rvc_step();
        do_reset();
        valid = 1; bjp = 1; prdt = 1; rslv = 0; rv32 = 0; pc = 32'h1FE; imm = 32'h100;
        tick();
        idle_inputs();
        #3;
        checks++;
        if (fpc_a !== 32'h200 || req_a !== 1'b1) begin
            failures++;
            $display("FAIL rvc_step2: pc=%h req=%b required pc=200 req=1", fpc_a, req_a);
        end
        checks++;
        if (fpc_n !== 32'h202 || req_n !== 1'b1) begin
            failures++;
            $display("FAIL norvc_step4: pc=%h req=%b required pc=202 req=1", fpc_n, req_n);
        end
        ack = 1;
        tick();
        ack = 0;
    endtask

    task automatic test_mret_override();
        do_reset();
        epc = 32'h1234;
        valid = 1; mret = 1; pc = 32'h40;
        tick();
        idle_inputs();
        nonalu = 1; ack = 1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (req_a !== 1'b0 || mena_a !== 1'b0) begin
                failures++;
                $display("FAIL mret_masked[%0d]: req=%b mret_ena=%b required 0 0", i, req_a, mena_a);
            end
            tick();
        end
        nonalu = 0;
        #3;
        checks++;
        if (req_a !== 1'b1 || fpc_a !== 32'h1234 || mena_a !== 1'b1) begin
            failures++;
            $display("FAIL mret_hsk: req=%b pc=%h mret_ena=%b required 1 1234 1", req_a, fpc_a, mena_a);
        end
        checks++;
        if (fena_a !== 1'b0 || dena_a !== 1'b0) begin
            failures++;
            $display("FAIL mret_kind: fencei_ena=%b dret_ena=%b required 0 0", fena_a, dena_a);
        end
        tick();
        #3;
        checks++;
        if (mena_a !== 1'b0 || req_a !== 1'b0 || cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL mret_after: mret_ena=%b req=%b cnt=%0d required 0 0 0", mena_a, req_a, cnt_a);
        end
        ack = 0;
    endtask

    task automatic test_dret_priority();
        do_reset();
        dpc = 32'hABC0; epc = 32'h1234;
        valid = 1; dret = 1; mret = 1; fencei = 1; pc = 32'h10;
        tick();
        idle_inputs();
        ack = 1;
        #3;
        checks++;
        if (fpc_a !== 32'hABC0 || dena_a !== 1'b1 || mena_a !== 1'b0) begin
            failures++;
            $display("FAIL dret_prio: pc=%h dret_ena=%b mret_ena=%b required abc0 1 0", fpc_a, dena_a, mena_a);
        end
        tick();
        ack = 0;
    endtask

    task automatic test_nonalu_block();
        do_reset();
        valid = 1; bjp = 1; prdt = 0; rslv = 1; pc = 32'h300; imm = 32'h8; nonalu = 1;
        #3;
        checks++;
        if (ready_a !== 1'b0) begin
            failures++;
            $display("FAIL nonalu_ready: ready=%b required 0", ready_a);
        end
        tick();
        idle_inputs();
        #3;
        checks++;
        if (req_a !== 1'b0 || cnt_a !== 16'd0 || ready_a !== 1'b1) begin
            failures++;
            $display("FAIL nonalu_nocapture: req=%b cnt=%0d ready=%b required 0 0 1", req_a, cnt_a, ready_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_c;
        do_reset();
        exp_c = 2'd0;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            valid = 1; bjp = 1; prdt = 0; rslv = 1; pc = 32'h1000; imm = 32'h10;
            tick();
            idle_inputs();
            ack = 1;
            if (exp_c != 2'd3) exp_c = exp_c + 2'd1;
            #3;
            checks++;
            if (cnt_c !== exp_c || req_c !== 1'b1) begin
                failures++;
                $display("FAIL sat_cnt[%0d]: cnt=%0d req=%b required cnt=%0d req=1", i, cnt_c, req_c, exp_c);
            end
            tick();
        end
        idle_inputs();
        #3;
        checks++;
        if (cnt_a !== 16'd5) begin
            failures++;
            $display("FAIL wide_cnt: cnt=%0d required 5", cnt_a);
        end
    endtask

    task automatic test_reset_in_pend();
        do_reset();
        valid = 1; fencei = 1; pc = 32'h2000;
        tick();
        idle_inputs();
        #3;
        checks++;
        if (req_a !== 1'b1 || fpc_a !== 32'h2004) begin
            failures++;
            $display("FAIL fencei_pend: req=%b pc=%h required 1 2004", req_a, fpc_a);
        end
        rst = 1; ack = 1;
        #1;
        checks++;
        if (req_a !== 1'b0 || fena_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_pend: req=%b fencei_ena=%b required 0 0", req_a, fena_a);
        end
        tick();
        rst = 0;
        valid = 1;
        #3;
        checks++;
        if (ready_a !== 1'b1 || req_a !== 1'b0 || fena_a !== 1'b0) begin
            failures++;
            $display("FAIL post_rst: ready=%b req=%b fencei_ena=%b required 1 0 0", ready_a, req_a, fena_a);
        end
        tick();
        ack = 0;
        valid = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1; epc = 0; dpc = 0;
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_rvc_step();
        test_mret_override();
        test_dret_priority();
        test_nonalu_block();
        test_back_to_back();
        test_reset_in_pend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
